// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, RV32 major opcodes,
// trap causes and the opcode classifier used by DECODE.
package mc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [6:0] op);
    case (op)
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_IMM, OP_REG, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: return CLS_ALU;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Memory wait-cycle counter; expired flags the waiting cycle that would bring
// the count up to TIMEOUT.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP
// state for illegal opcodes and memory timeouts.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_wr,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we_en,
  output logic        retire,
  output logic [31:0] retire_count,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  op_class_e   r_cls;
  logic [1:0]  r_trap_cause;
  logic [31:0] r_retire_count;
  logic        w_fetch_req;
  logic        w_mem_req;
  logic        w_expired;
  logic        w_ctr_clear;
  logic        w_ctr_en;

  // The fetch request is gated by reset so nothing is requested while held in reset.
  assign w_fetch_req = reset && (r_state == ST_FETCH) && run;
  assign w_mem_req   = w_fetch_req || (r_state == ST_MEM);
  assign w_ctr_en    = w_mem_req && !mem_ack;
  assign w_ctr_clear = (r_state == ST_EXEC) || (r_state == ST_WB);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_ctr_clear),
    .en      (w_ctr_en),
    .expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_fetch_req && mem_ack) w_next = ST_DECODE;
        else if (w_expired)         w_next = ST_TRAP;
      end
      ST_DECODE: w_next = (op_class(opcode) == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC:   w_next = (r_cls == CLS_LOAD || r_cls == CLS_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ack)        w_next = ST_WB;
        else if (w_expired) w_next = ST_TRAP;
      end
      ST_WB:     w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_FETCH;
      r_cls          <= CLS_ALU;
      r_trap_cause   <= CAUSE_NONE;
      r_retire_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_cls <= op_class(opcode);
      if (r_state != ST_TRAP && w_next == ST_TRAP)
        r_trap_cause <= (r_state == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      if (r_state == ST_WB) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign mem_req      = w_mem_req;
  assign mem_sel      = (r_state == ST_MEM);
  assign mem_wr       = (r_state == ST_MEM) && (r_cls == CLS_STORE);
  assign ir_we        = w_fetch_req && mem_ack;
  assign pc_we        = (r_state == ST_WB);
  assign retire       = (r_state == ST_WB);
  assign rf_we_en     = (r_state == ST_WB) && (r_cls != CLS_STORE) && (r_cls != CLS_BRANCH);
  assign trap         = (r_state == ST_TRAP);
  assign trap_cause   = r_trap_cause;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: each instruction is expanded into a per-cycle expected
// trace (request/wait/ack phases, trap tails) and replayed against the design.
module tb_mc_sequencer;

  localparam int TIMEOUT = 15;

  localparam logic [6:0] T_ADDI = 7'b0010011;
  localparam logic [6:0] T_LOAD = 7'b0000011;
  localparam logic [6:0] T_STOR = 7'b0100011;
  localparam logic [6:0] T_BRAN = 7'b1100011;
  localparam logic [6:0] LEGAL [9] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                                       7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111,
                                       7'b0110111};

  // Expected output bits, ordered {req, sel, wr, ir_we, pc_we, rf_we_en, retire, trap}
  localparam logic [7:0] E_REQ  = 8'h80;
  localparam logic [7:0] E_SEL  = 8'h40;
  localparam logic [7:0] E_WR   = 8'h20;
  localparam logic [7:0] E_IR   = 8'h10;
  localparam logic [7:0] E_PC   = 8'h08;
  localparam logic [7:0] E_RF   = 8'h04;
  localparam logic [7:0] E_RET  = 8'h02;
  localparam logic [7:0] E_TRAP = 8'h01;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_sel, mem_wr, ir_we, pc_we, rf_we_en, retire, trap;
  logic [31:0] retire_count;
  logic [1:0]  trap_cause;

  mc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_sel      (mem_sel),
    .mem_wr       (mem_wr),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we_en     (rf_we_en),
    .retire       (retire),
    .retire_count (retire_count),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic        ack;
    logic [7:0]  exp;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } step_t;

  step_t       q[$];
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] outs();
    return {mem_req, mem_sel, mem_wr, ir_we, pc_we, rf_we_en, retire, trap};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic r, input logic a, input logic [7:0] e,
                               input logic [1:0] c);
    step_t s;
    s.run = r; s.ack = a; s.exp = e; s.cause = c; s.cnt = m_cnt;
    q.push_back(s);
  endfunction

  function automatic void push_trap(input logic [1:0] c);
    for (int i = 0; i < 4; i++) push(rbit(), rbit(), E_TRAP, c);
  endfunction

  // One memory access: w waiting cycles, then the ack cycle; TIMEOUT waits trap instead.
  function automatic bit push_access(input int w, input logic [7:0] e_wait,
                                     input logic [7:0] e_ack);
    if (w >= TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++) push(1'b1, 1'b0, e_wait, 2'd0);
      push_trap(2'd2);
      return 1'b1;
    end
    for (int i = 0; i < w; i++) push(1'b1, 1'b0, e_wait, 2'd0);
    push(1'b1, 1'b1, e_ack, 2'd0);
    return 1'b0;
  endfunction

  // Expected trace of one instruction; returns 1 when it ends in TRAP.
  function automatic bit build(input logic [6:0] op, input int w1, input int w2, input int npause);
    bit          ls;
    bit          st;
    logic [7:0]  e;
    ls = (op == T_LOAD) || (op == T_STOR);
    st = (op == T_STOR);
    for (int i = 0; i < npause; i++) push(1'b0, rbit(), 8'h00, 2'd0);
    if (push_access(w1, E_REQ, E_REQ | E_IR)) return 1'b1;
    push(1'b1, rbit(), 8'h00, 2'd0);
    if (!is_legal(op)) begin
      push_trap(2'd1);
      return 1'b1;
    end
    push(1'b1, rbit(), 8'h00, 2'd0);
    if (ls) begin
      e = E_REQ | E_SEL | (st ? E_WR : 8'h00);
      if (push_access(w2, e, e)) return 1'b1;
    end
    push(1'b1, rbit(), E_PC | E_RET | ((st || op == T_BRAN) ? 8'h00 : E_RF), 2'd0);
    m_cnt++;
    return 1'b0;
  endfunction

  task automatic play(input int n);
    step_t s;
    int    k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      run = s.run;
      mem_ack = s.ack;
      @(negedge clk);
      chk($sformatf("outs@%0t", $time), 32'(outs()), 32'(s.exp));
      chk($sformatf("cause@%0t", $time), 32'(trap_cause), 32'(s.cause));
      chk($sformatf("count@%0t", $time), retire_count, s.cnt);
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic do_reset();
    run = 1'b1;
    mem_ack = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst outs", 32'(outs()), 32'd0);
    chk("rst count", retire_count, 32'd0);
    chk("rst cause", 32'(trap_cause), 32'd0);
    @(negedge clk);
    chk("rst hold outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    run = 1'b0;
    mem_ack = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst exit outs", 32'(outs()), 32'd0);
    chk("rst exit cause", 32'(trap_cause), 32'd0);
    @(posedge clk);
    #1;
    m_cnt = 0;
    q.delete();
  endtask

  task automatic do_instr(input logic [6:0] op, input int w1, input int w2, input int npause);
    bit trapped;
    opcode = op;
    trapped = build(op, w1, w2, npause);
    play(-1);
    if (trapped) do_reset();
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 18) return TIMEOUT - 1;
    return TIMEOUT;
  endfunction

  initial begin
    logic [6:0] op;
    m_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    do_instr(T_ADDI, 0, 0, 0);
    chk("addi retired", retire_count, 32'd1);
    do_instr(T_LOAD, 0, 2, 0);
    do_instr(T_STOR, 0, 0, 0);
    do_instr(T_BRAN, 0, 0, 0);
    do_instr(T_ADDI, 1, 0, 3);
    do_instr(7'h7F, 0, 0, 0);
    do_instr(T_ADDI, TIMEOUT, 0, 0);
    do_instr(T_ADDI, TIMEOUT - 1, 0, 0);
    do_instr(T_LOAD, 0, TIMEOUT, 0);
    do_instr(T_STOR, 2, TIMEOUT - 1, 0);

    // Reset in the middle of a data access, released with run already high
    opcode = T_LOAD;
    void'(build(T_LOAD, 0, 6, 0));
    play(4);
    q.delete();
    run = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("midmem req/sel", 32'({mem_req, mem_sel}), 32'b11);
    reset = 1'b0;
    #1;
    chk("midmem rst outs", 32'(outs()), 32'd0);
    chk("midmem rst count", retire_count, 32'd0);
    @(posedge clk);
    #1;
    chk("midmem hold outs", 32'(outs()), 32'd0);
    reset = 1'b1;
    #1;
    chk("post-rst first req", 32'({mem_req, mem_sel, ir_we}), 32'b100);
    m_cnt = 0;
    do_instr(T_ADDI, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end else begin
        op = LEGAL[$urandom_range(0, 8)];
      end
      do_instr(op, rand_wait(), rand_wait(), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
